// File: rtl/stepper_pkg.sv
// Shared stepper definitions: phase codes, FSM encoding, direction constants and the
// phase decoder used by both the drive sequencer and the phase monitor.
package stepper_pkg;

    localparam logic [3:0] PH0    = 4'b0001;
    localparam logic [3:0] PH1    = 4'b0010;
    localparam logic [3:0] PH2    = 4'b0100;
    localparam logic [3:0] PH3    = 4'b1000;
    localparam logic [3:0] PH_OFF = 4'b0000;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLocked = 2'd1,
        StFault  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PhValid   = 2'd0,
        PhOff     = 2'd1,
        PhIllegal = 2'd2
    } ph_class_e;

    typedef struct packed {
        ph_class_e  cls;
        logic [1:0] idx;
    } ph_dec_t;

    function automatic ph_dec_t phase_decode(input logic [3:0] p);
        ph_dec_t d;
        d.cls = PhValid;
        d.idx = 2'd0;
        case (p)
            PH0:     d.idx = 2'd0;
            PH1:     d.idx = 2'd1;
            PH2:     d.idx = 2'd2;
            PH3:     d.idx = 2'd3;
            PH_OFF:  d.cls = PhOff;
            default: d.cls = PhIllegal;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/phase_filter.sv
// Two-flop synchronizer plus stability filter; strobes accept once per newly stable
// pattern.
module phase_filter #(
    parameter int unsigned FILT_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] f_in,
    output logic [3:0] pattern,
    output logic       accept
);

    localparam int unsigned CW = $clog2(FILT_CYC + 1);
    localparam logic [CW-1:0] CntMax = CW'(FILT_CYC);

    logic [3:0]    sync1_q, sync2_q, cand_q, last_q, pattern_q;
    logic [3:0]    last_d, pattern_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept_q, accept_d, changed;

    always_comb begin
        changed   = (sync2_q != cand_q);
        cnt_d     = cnt_q;
        accept_d  = 1'b0;
        last_d    = last_q;
        pattern_d = pattern_q;
        if (changed) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CW'(1);
        end
        // Only the cycle the count first reaches CntMax accepts, and never the pattern
        // that was accepted last, so a glitch that returns to it is invisible.
        if ((cnt_d == CntMax) && (changed || cnt_q != CntMax) && (sync2_q != last_q)) begin
            accept_d  = 1'b1;
            last_d    = sync2_q;
            pattern_d = sync2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cand_q    <= '0;
            last_q    <= '0;
            pattern_q <= '0;
            cnt_q     <= '0;
            accept_q  <= 1'b0;
        end else begin
            sync1_q   <= f_in;
            sync2_q   <= sync1_q;
            cand_q    <= sync2_q;
            last_q    <= last_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            accept_q  <= accept_d;
        end
    end

    assign pattern = pattern_q;
    assign accept  = accept_q;

endmodule

// File: rtl/stepper_phase_monitor.sv
// Decodes filtered stepper phase lines into step pulses, direction, position and step
// period, flagging illegal or skipped phases with a sticky fault.
module stepper_phase_monitor
    import stepper_pkg::*;
#(
    parameter int unsigned POS_W    = 16,
    parameter int unsigned PER_W    = 20,
    parameter int unsigned FILT_CYC = 4,
    parameter int unsigned TIMEOUT  = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              f_in,
    input  logic                    pos_clr,
    input  logic                    clr_fault,
    output logic                    step_fwd,
    output logic                    step_rev,
    output logic                    dir,
    output logic                    moving,
    output logic signed [POS_W-1:0] position,
    output logic [PER_W-1:0]        period,
    output logic                    period_valid,
    output logic                    locked,
    output logic                    fault
);

    localparam logic [PER_W-1:0] TimeoutCnt = PER_W'(TIMEOUT);

    logic [3:0] acc_pattern;
    logic       accept;

    phase_filter #(
        .FILT_CYC(FILT_CYC)
    ) u_phase_filter (
        .clk    (clk),
        .rst    (rst),
        .f_in   (f_in),
        .pattern(acc_pattern),
        .accept (accept)
    );

    state_e                  state_q, state_d;
    logic [1:0]              idx_q, idx_d, diff;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic [PER_W-1:0]        cnt_q, cnt_d, per_q, per_d;
    logic                    dir_q, dir_d, fwd_q, fwd_d, rev_q, rev_d;
    logic                    mov_q, mov_d, pv_q, pv_d, seen_q, seen_d;
    ph_dec_t                 dec;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        dir_d   = dir_q;
        fwd_d   = 1'b0;
        rev_d   = 1'b0;
        mov_d   = mov_q;
        pv_d    = pv_q;
        seen_d  = seen_q;
        dec     = phase_decode(acc_pattern);
        diff    = dec.idx - idx_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (dec.cls)
                        PhValid: begin
                            state_d = StLocked;
                            idx_d   = dec.idx;
                            cnt_d   = PER_W'(1);
                            seen_d  = 1'b0;
                        end
                        PhIllegal: state_d = StFault;
                        default: ;
                    endcase
                end
            end
            StLocked: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + PER_W'(1);
                end
                if (cnt_q == TimeoutCnt) begin
                    mov_d = 1'b0;
                end
                if (accept) begin
                    case (dec.cls)
                        PhOff:     state_d = StIdle;
                        PhIllegal: state_d = StFault;
                        default: begin
                            if (diff == 2'd1 || diff == 2'd3) begin
                                fwd_d  = (diff == 2'd1);
                                rev_d  = (diff == 2'd3);
                                dir_d  = (diff == 2'd1) ? DIR_FWD : DIR_REV;
                                pos_d  = (diff == 2'd1) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                                idx_d  = dec.idx;
                                per_d  = cnt_q;
                                cnt_d  = PER_W'(1);
                                mov_d  = 1'b1;
                                seen_d = 1'b1;
                                if (seen_q) begin
                                    pv_d = 1'b1;
                                end
                            end else if (diff == 2'd2) begin
                                state_d = StFault;
                            end
                        end
                    endcase
                end
            end
            StFault: begin
                if (clr_fault) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q == StLocked && state_d != StLocked) begin
            pv_d  = 1'b0;
            mov_d = 1'b0;
        end
        // Clear beats a coincident step; the pulse and dir update still go out.
        if (pos_clr) begin
            pos_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            pos_q   <= '0;
            cnt_q   <= '0;
            per_q   <= '0;
            dir_q   <= 1'b0;
            fwd_q   <= 1'b0;
            rev_q   <= 1'b0;
            mov_q   <= 1'b0;
            pv_q    <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            dir_q   <= dir_d;
            fwd_q   <= fwd_d;
            rev_q   <= rev_d;
            mov_q   <= mov_d;
            pv_q    <= pv_d;
            seen_q  <= seen_d;
        end
    end

    assign step_fwd     = fwd_q;
    assign step_rev     = rev_q;
    assign dir          = dir_q;
    assign moving       = mov_q;
    assign position     = pos_q;
    assign period       = per_q;
    assign period_valid = pv_q;
    assign locked       = (state_q == StLocked);
    assign fault        = (state_q == StFault);

endmodule

// File: tb/tb_stepper_phase_monitor.sv
// Directed bench for stepper_phase_monitor: expected steps are queued when phases are
// driven and matched against the pulses the DUT emits.
module tb_stepper_phase_monitor;

    localparam int unsigned POS_W = 4;
    localparam int unsigned PER_W = 20;
    localparam int unsigned FILT_CYC = 4;
    localparam int unsigned TIMEOUT = 100;
    localparam int unsigned LAT = 2 + FILT_CYC + 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [3:0]              f_in = 4'b0000;
    logic                    pos_clr = 1'b0;
    logic                    clr_fault = 1'b0;
    logic                    step_fwd, step_rev, dir, moving, period_valid, locked, fault;
    logic signed [POS_W-1:0] position;
    logic [PER_W-1:0]        period;

    stepper_phase_monitor #(
        .POS_W   (POS_W),
        .PER_W   (PER_W),
        .FILT_CYC(FILT_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .f_in        (f_in),
        .pos_clr     (pos_clr),
        .clr_fault   (clr_fault),
        .step_fwd    (step_fwd),
        .step_rev    (step_rev),
        .dir         (dir),
        .moving      (moving),
        .position    (position),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic                    fwd;
        logic signed [POS_W-1:0] pos;
        int unsigned             cyc;
    } exp_t;

    exp_t                    sb[$];
    exp_t                    mon_e;
    int                      checks = 0;
    int                      errors = 0;
    logic [1:0]              idx_m = 2'd0;
    logic signed [POS_W-1:0] pos_m = '0;
    int unsigned             s_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (step_fwd === 1'b1 || step_rev === 1'b1) begin
            check("step_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("step_fwd", 32'(step_fwd), 32'(mon_e.fwd));
                check("step_rev", 32'(step_rev), 32'(!mon_e.fwd));
                check("step_latency", cyc, mon_e.cyc);
                check("step_pos", 32'(position), 32'(mon_e.pos));
                check("step_dir", 32'(dir), 32'(mon_e.fwd));
            end
        end
    end

    task automatic drive(input logic [3:0] p, input int hold, input bit step, input bit fwd);
        @(posedge clk);
        #1;
        f_in = p;
        if (step) begin
            pos_m = fwd ? pos_m + 4'sd1 : pos_m - 4'sd1;
            sb.push_back('{fwd: fwd, pos: pos_m, cyc: cyc + LAT});
        end
        repeat (hold - 1) @(posedge clk);
    endtask

    task automatic step_to(input bit fwd, input int hold);
        idx_m = fwd ? idx_m + 2'd1 : idx_m - 2'd1;
        drive(4'b0001 << idx_m, hold, 1'b1, fwd);
    endtask

    task automatic pulse_clr_fault();
        @(posedge clk);
        #1 clr_fault = 1'b1;
        @(posedge clk);
        #1 clr_fault = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_fwd"}, 32'(step_fwd), 32'd0);
        check({tag, "_rev"}, 32'(step_rev), 32'd0);
        check({tag, "_dir"}, 32'(dir), 32'd0);
        check({tag, "_moving"}, 32'(moving), 32'd0);
        check({tag, "_position"}, 32'(position), 32'd0);
        check({tag, "_period"}, 32'(period), 32'd0);
        check({tag, "_pvalid"}, 32'(period_valid), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Forward run
        drive(4'b0001, 50, 1'b0, 1'b0);
        @(negedge clk);
        check("fwd_locked", 32'(locked), 32'd1);
        check("fwd_no_pulse_pos", 32'(position), 32'd0);
        step_to(1'b1, 50);
        @(negedge clk);
        check("fwd_pvalid_step1", 32'(period_valid), 32'd0);
        step_to(1'b1, 50);
        @(negedge clk);
        check("fwd_period", 32'(period), 32'd50);
        check("fwd_pvalid_step2", 32'(period_valid), 32'd1);
        step_to(1'b1, 50);
        step_to(1'b1, 50);
        @(negedge clk);
        check("fwd_position", 32'(position), 32'(pos_m));
        check("fwd_position_abs", 32'(position), 32'd4);
        check("fwd_dir", 32'(dir), 32'd1);
        check("fwd_moving", 32'(moving), 32'd1);

        // Reverse and wrap
        @(posedge clk);
        #1 pos_clr = 1'b1;
        @(posedge clk);
        #1 pos_clr = 1'b0;
        pos_m = '0;
        @(negedge clk);
        check("posclr_position", 32'(position), 32'd0);
        for (int i = 0; i < 9; i++) step_to(1'b0, 20);
        @(negedge clk);
        check("rev_wrap_position", 32'(position), 32'(pos_m));
        check("rev_wrap_abs", 32'(position), 32'(4'sd7));
        check("rev_dir", 32'(dir), 32'd0);

        // Glitch rejection on 0010
        step_to(1'b1, 20);
        step_to(1'b1, 20);
        drive(4'b0100, 2, 1'b0, 1'b0);
        drive(4'b0010, 30, 1'b0, 1'b0);
        @(negedge clk);
        check("glitch_position", 32'(position), 32'(pos_m));
        check("glitch_fault", 32'(fault), 32'd0);
        check("glitch_locked", 32'(locked), 32'd1);

        // Clear/step collision
        @(posedge clk);
        #1 f_in = 4'b0100;
        idx_m = 2'd2;
        pos_m = '0;
        sb.push_back('{fwd: 1'b1, pos: pos_m, cyc: cyc + LAT});
        repeat (LAT - 1) @(posedge clk);
        #1 pos_clr = 1'b1;
        @(posedge clk);
        #1 pos_clr = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("collide_position", 32'(position), 32'd0);
        check("collide_dir", 32'(dir), 32'd1);

        // Skip and illegal
        step_to(1'b0, 20);
        step_to(1'b0, 20);
        drive(4'b0100, 20, 1'b0, 1'b0);
        @(negedge clk);
        check("skip_fault", 32'(fault), 32'd1);
        check("skip_locked", 32'(locked), 32'd0);
        check("skip_position", 32'(position), 32'(pos_m));
        pulse_clr_fault();
        @(negedge clk);
        check("clr_fault_cleared", 32'(fault), 32'd0);
        drive(4'b0110, 20, 1'b0, 1'b0);
        @(negedge clk);
        check("illegal_fault", 32'(fault), 32'd1);
        check("illegal_position", 32'(position), 32'(pos_m));
        pulse_clr_fault();
        drive(4'b0000, 20, 1'b0, 1'b0);
        @(negedge clk);
        check("off_fault", 32'(fault), 32'd0);
        check("off_locked", 32'(locked), 32'd0);

        // Timeout
        idx_m = 2'd0;
        drive(4'b0001, 20, 1'b0, 1'b0);
        @(negedge clk);
        check("relock_locked", 32'(locked), 32'd1);
        step_to(1'b1, 1);
        s_cyc = cyc + LAT;
        while (cyc < s_cyc + TIMEOUT - 1) @(negedge clk);
        check("timeout_before", 32'(moving), 32'd1);
        @(negedge clk);
        check("timeout_after", 32'(moving), 32'd0);
        check("timeout_locked", 32'(locked), 32'd1);
        repeat (50) @(negedge clk);

        // Reset mid-filter
        @(posedge clk);
        #1 f_in = 4'b0100;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        pos_m = '0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("postrst_locked", 32'(locked), 32'd1);
        check("postrst_position", 32'(position), 32'd0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
